// File: rtl/vip_cfg_arbiter_pkg.sv
// Shared defaults and FSM encoding for the video IP configuration-port arbiter.
package vip_cfg_arbiter_pkg;

  localparam int N_REQ_DEF    = 3;
  localparam int AW_DEF       = 9;
  localparam int DW_DEF       = 32;
  localparam int HOLD_MAX_DEF = 255;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/vip_cfg_arbiter_if.sv
// Requester-side and IP-side Avalon-MM write signals of the configuration arbiter.
interface vip_cfg_arbiter_if
  import vip_cfg_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
);

  logic [N_REQ-1:0]    req_write;
  logic [N_REQ*AW-1:0] req_address;
  logic [N_REQ*DW-1:0] req_writedata;
  logic [N_REQ-1:0]    req_lock;
  logic [N_REQ-1:0]    req_waitrequest;
  logic [AW-1:0]       address;
  logic                write;
  logic [DW-1:0]       writedata;
  logic                waitrequest;
  logic [N_REQ-1:0]    grant;
  logic                hold_err;

  modport slave (
    input  req_write, req_address, req_writedata, req_lock, waitrequest,
    output req_waitrequest, address, write, writedata, grant, hold_err
  );

  modport master (
    output req_write, req_address, req_writedata, req_lock, waitrequest,
    input  req_waitrequest, address, write, writedata, grant, hold_err
  );

endinterface

// File: rtl/vip_cfg_arbiter_rr_pick.sv
// Round-robin pick: first requester at or after ptr_i (wrapping) as one-hot and index.
module vip_cfg_arbiter_rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int off = 0; off < N; off++) begin
      j = int'(ptr_i) + off;
      if (j >= N) begin
        j = j - N;
      end else begin
        j = j;
      end
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/vip_cfg_arbiter.sv
// Shares the write-only configuration port between requesters: round-robin
// ownership, lock for atomic write sequences, forced release of idle locked owners.
module vip_cfg_arbiter
  import vip_cfg_arbiter_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input logic              clk,
  input logic              reset,
  vip_cfg_arbiter_if.slave bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
  localparam logic [PW-1:0] LAST_IDX  = PW'(N_REQ - 1);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             hold_err_q, hold_err_d;

  logic [N_REQ-1:0] cand_s, pick_gnt_s;
  logic [PW-1:0]    pick_idx_s;
  logic             pick_any_s;
  logic             own_write_s, own_lock_s, accept_s;
  logic [AW-1:0]    addr_s;
  logic [DW-1:0]    wdata_s;

  assign cand_s = bus.req_write | bus.req_lock;

  vip_cfg_arbiter_rr_pick #(.N(N_REQ), .PW(PW)) u_rr_pick (
    .req_i (cand_s),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt_s),
    .idx_o (pick_idx_s),
    .any_o (pick_any_s)
  );

  assign own_write_s = bus.req_write[owner_q];
  assign own_lock_s  = bus.req_lock[owner_q];
  assign accept_s    = own_write_s & ~bus.waitrequest;

  // Next-state logic; an in-flight transfer (write & waitrequest) always keeps the grant.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_d     = hold_q;
    hold_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        hold_d = '0;
        if (pick_any_s) begin
          grant_d  = pick_gnt_s;
          owner_d  = pick_idx_s;
          rr_ptr_d = (pick_idx_s == LAST_IDX) ? '0 : pick_idx_s + PW'(1);
          state_d  = OWNED;
        end else begin
          state_d = IDLE;
        end
      end
      OWNED: begin
        if (own_write_s) begin
          hold_d = '0;
          if (accept_s && !own_lock_s) begin
            grant_d = '0;
            state_d = IDLE;
          end else begin
            state_d = OWNED;
          end
        end else if (!own_lock_s) begin
          grant_d = '0;
          hold_d  = '0;
          state_d = IDLE;
        end else if (hold_q == HOLD_LAST) begin
          grant_d    = '0;
          hold_d     = '0;
          hold_err_d = 1'b1;
          state_d    = IDLE;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        grant_d = '0;
        hold_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Arbiter state registers; reset drops the grant immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_q     <= '0;
      hold_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_q     <= hold_d;
      hold_err_q <= hold_err_d;
    end
  end

  // AND-OR mux of the owner's address/data; all zero when nobody holds the grant.
  always_comb begin
    addr_s  = '0;
    wdata_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      addr_s  = addr_s  | (bus.req_address[i*AW +: AW]   & {AW{grant_q[i]}});
      wdata_s = wdata_s | (bus.req_writedata[i*DW +: DW] & {DW{grant_q[i]}});
    end
  end

  assign bus.write           = |(grant_q & bus.req_write);
  assign bus.address         = addr_s;
  assign bus.writedata       = wdata_s;
  assign bus.req_waitrequest = ~grant_q | {N_REQ{bus.waitrequest}};
  assign bus.grant           = grant_q;
  assign bus.hold_err        = hold_err_q;

endmodule

// File: tb/tb_vip_cfg_arbiter.sv
// Randomized scoreboard bench for vip_cfg_arbiter: per-requester Avalon drivers,
// transaction-level round-robin/lock model, decoupled output monitor.
module tb_vip_cfg_arbiter;

  localparam int N    = 3;
  localparam int AW   = 9;
  localparam int DW   = 32;
  localparam int HOLD = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          lock;
  } item_t;

  typedef struct packed {
    logic [7:0]    req;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  vip_cfg_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus ();

  vip_cfg_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .HOLD_MAX(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  item_t    pend[N][$];
  item_t    stim[N][$];
  exp_t     exp_q[$];
  bit       drv_en    = 1'b0;
  int       wr_mode   = 0;
  logic [N-1:0] hold_lock = '0;
  bit       acc[N];
  int       n_checks  = 0;
  int       n_errors  = 0;
  int       model_ptr = 0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Requester drivers: hold write until accepted, then present the next queued item.
  initial begin
    bus.req_write     = '0;
    bus.req_address   = '0;
    bus.req_writedata = '0;
    bus.req_lock      = '0;
    bus.waitrequest   = 1'b0;
    forever begin
      @(negedge clk);
      if (drv_en) begin
        for (int i = 0; i < N; i++) begin
          if (acc[i] && pend[i].size() > 0) void'(pend[i].pop_front());
        end
        for (int i = 0; i < N; i++) begin
          if (pend[i].size() > 0) begin
            bus.req_write[i]             = 1'b1;
            bus.req_address[i*AW +: AW]  = pend[i][0].addr;
            bus.req_writedata[i*DW +: DW] = pend[i][0].data;
            bus.req_lock[i]              = pend[i][0].lock | hold_lock[i];
          end else begin
            bus.req_write[i] = 1'b0;
            bus.req_lock[i]  = hold_lock[i];
          end
        end
        if (wr_mode == 1)      bus.waitrequest = ($urandom_range(0, 2) == 0);
        else if (wr_mode == 2) bus.waitrequest = 1'b1;
        else                   bus.waitrequest = 1'b0;
      end
      #4;
      for (int i = 0; i < N; i++)
        acc[i] = drv_en && !reset && bus.req_write[i] && !bus.req_waitrequest[i];
    end
  end

  // Output monitor: bus invariants every cycle, scoreboard compare on each accepted write.
  initial begin
    logic [N-1:0] prev_g;
    exp_t e;
    int r;
    prev_g = '0;
    forever begin
      @(negedge clk);
      #4;
      if (reset) begin
        prev_g = '0;
      end else begin
        chk($onehot0(bus.grant), "grant_onehot", 64'(bus.grant), 64'd0);
        if (bus.grant == '0)
          chk(!bus.write && bus.address == '0 && bus.writedata == '0 && bus.req_waitrequest == '1,
              "idle_outputs", {bus.write, bus.req_waitrequest, bus.address}, {1'b0, 3'b111, 9'h0});
        else
          chk(bus.req_waitrequest == (~bus.grant | {N{bus.waitrequest}}), "req_waitrequest",
              64'(bus.req_waitrequest), 64'(~bus.grant | {N{bus.waitrequest}}));
        if (bus.grant != '0 && bus.grant != prev_g)
          chk(prev_g == '0, "idle_gap", 64'(prev_g), 64'd0);
        if (bus.write && !bus.waitrequest) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_write", 64'(bus.address), 64'd0);
          end else begin
            e = exp_q.pop_front();
            r = 0;
            for (int i = 0; i < N; i++) if (bus.grant[i]) r = i;
            chk(r == int'(e.req), "owner", 64'(r), 64'(e.req));
            chk(bus.address == e.addr, "address", 64'(bus.address), 64'(e.addr));
            chk(bus.writedata == e.data, "writedata", 64'(bus.writedata), 64'(e.data));
          end
        end
        prev_g = bus.grant;
      end
    end
  end

  task automatic sample();
    @(negedge clk);
    #4;
  endtask

  task automatic add_item(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit lk);
    item_t it;
    it.addr = a;
    it.data = d;
    it.lock = lk;
    stim[r].push_back(it);
  endtask

  // Random stimulus: bursts of 1..4 writes; a locked burst keeps lock up to its last write.
  task automatic gen_stim(input int max_bursts);
    int nb, len;
    bit lk;
    for (int r = 0; r < N; r++) begin
      nb = $urandom_range(0, max_bursts);
      for (int b = 0; b < nb; b++) begin
        len = $urandom_range(1, 4);
        lk  = ($urandom_range(0, 1) == 1);
        for (int k = 0; k < len; k++)
          add_item(r, AW'($urandom), $urandom, lk && (k != len - 1));
      end
    end
  endtask

  // Reference: serve the first pending requester from the rr pointer; a locked run is
  // served whole, an unlocked write alone; pointer moves past the winner.
  task automatic run_phase(input string nm);
    item_t tmp[N][$];
    item_t it;
    exp_t  e;
    int total, r, cyc;
    bit busy;
    total = 0;
    for (int i = 0; i < N; i++) begin
      tmp[i] = stim[i];
      total += tmp[i].size();
    end
    while (total > 0) begin
      r = -1;
      for (int off = 0; off < N; off++)
        if (r < 0 && tmp[(model_ptr + off) % N].size() > 0) r = (model_ptr + off) % N;
      do begin
        it = tmp[r].pop_front();
        total--;
        e.req  = 8'(r);
        e.addr = it.addr;
        e.data = it.data;
        exp_q.push_back(e);
      end while (it.lock && tmp[r].size() > 0);
      model_ptr = (r + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      foreach (stim[i][j]) pend[i].push_back(stim[i][j]);
      stim[i].delete();
    end
    cyc  = 0;
    busy = 1'b1;
    while (busy && cyc < 3000) begin
      sample();
      cyc++;
      busy = (exp_q.size() > 0);
      for (int i = 0; i < N; i++) if (pend[i].size() > 0) busy = 1'b1;
    end
    chk(!busy, {"drain_", nm}, 64'(exp_q.size()), 64'd0);
    if (busy) begin
      exp_q.delete();
      for (int i = 0; i < N; i++) pend[i].delete();
    end
    repeat (2) sample();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, n;
    item_t it;
    exp_t e;
    // Reset: outputs quiet even with every requester active.
    #1;
    bus.req_write = '1;
    bus.req_lock  = '1;
    repeat (3) sample();
    chk(!bus.write, "reset_write", 64'(bus.write), 64'd0);
    chk(bus.grant == '0, "reset_grant", 64'(bus.grant), 64'd0);
    chk(bus.req_waitrequest == 3'b111, "reset_req_wait", 64'(bus.req_waitrequest), 64'h7);
    chk(!bus.hold_err && bus.address == '0 && bus.writedata == '0, "reset_bus", 64'(bus.address), 64'd0);
    bus.req_write = '0;
    bus.req_lock  = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) sample();
    chk(bus.grant == '0, "idle_no_req", 64'(bus.grant), 64'd0);
    drv_en = 1'b1;
    sample();

    // Single write: one cycle of arbitration, write accepted on the owned cycle.
    it = '{addr: 9'h004, data: 32'h0, lock: 1'b0};
    pend[0].push_back(it);
    e = '{req: 8'd0, addr: 9'h004, data: 32'h0};
    exp_q.push_back(e);
    model_ptr = 1;
    sample();
    chk(bus.grant == 3'b000, "single_arb_cycle", 64'(bus.grant), 64'd0);
    sample();
    chk(bus.grant == 3'b001 && bus.write && bus.req_waitrequest == 3'b110, "single_grant",
        {bus.grant, bus.write, bus.req_waitrequest}, {3'b001, 1'b1, 3'b110});
    sample();
    chk(bus.grant == 3'b000 && !bus.write, "single_release", 64'(bus.grant), 64'd0);
    repeat (2) sample();

    // Contention from rr_ptr=1 (order 1,2,0), then from rr_ptr=0 (order 0,1,2).
    for (int r = 0; r < N; r++) add_item(r, AW'(9'h010 + r), 32'hA000_0000 + r, 1'b0);
    run_phase("contend_p1");
    add_item(2, 9'h01F, 32'h0000_0F0F, 1'b0);
    run_phase("set_ptr0");
    for (int r = 0; r < N; r++) add_item(r, AW'(9'h020 + r), 32'hB000_0000 + r, 1'b0);
    run_phase("contend_p0");

    // Locked sequence from req1 with req0 pending, stalled by random waitrequest.
    add_item(0, 9'h001, 32'h1111_0000, 1'b0);
    run_phase("set_ptr1");
    wr_mode = 1;
    add_item(1, 9'h008, 32'hC0DE_0008, 1'b1);
    add_item(1, 9'h00E, 32'hC0DE_000E, 1'b1);
    add_item(1, 9'h00F, 32'hC0DE_000F, 1'b1);
    add_item(1, 9'h009, 32'hC0DE_0009, 1'b0);
    add_item(0, 9'h002, 32'h2222_0000, 1'b0);
    run_phase("lock_seq");

    for (int p = 0; p < 8; p++) begin
      gen_stim(3);
      run_phase("random");
    end

    // Hold timeout: req1 locks without writing, then req0 waits for the forced release.
    wr_mode = 0;
    hold_lock[1] = 1'b1;
    cyc = 0;
    while (bus.grant != 3'b010 && cyc < 20) begin
      sample();
      cyc++;
    end
    chk(bus.grant == 3'b010, "hold_grant", 64'(bus.grant), 64'h2);
    it = '{addr: 9'h0AA, data: 32'hDEAD_BEEF, lock: 1'b0};
    pend[0].push_back(it);
    e = '{req: 8'd0, addr: 9'h0AA, data: 32'hDEAD_BEEF};
    exp_q.push_back(e);
    n = 0;
    while (bus.grant == 3'b010 && n < 40) begin
      n++;
      sample();
    end
    chk(n == HOLD, "hold_cycles", 64'(n), 64'(HOLD));
    chk(bus.hold_err && bus.grant == '0, "hold_err_pulse", {bus.hold_err, bus.grant}, {1'b1, 3'b000});
    hold_lock[1] = 1'b0;
    sample();
    chk(!bus.hold_err, "hold_err_single", 64'(bus.hold_err), 64'd0);
    chk(bus.grant == 3'b001, "hold_next_owner", 64'(bus.grant), 64'h1);
    model_ptr = 1;
    run_phase("hold_drain");

    // Reset while req2 holds a locked, stalled write: grant and write drop at once.
    wr_mode = 2;
    hold_lock[2] = 1'b1;
    add_item(2, 9'h1F0, 32'h5555_AAAA, 1'b1);
    for (int i = 0; i < N; i++) begin
      foreach (stim[i][j]) pend[i].push_back(stim[i][j]);
      stim[i].delete();
    end
    cyc = 0;
    while (!(bus.grant == 3'b100 && bus.write) && cyc < 20) begin
      sample();
      cyc++;
    end
    chk(bus.grant == 3'b100 && bus.write, "midlock_owned", {bus.grant, bus.write}, {3'b100, 1'b1});
    @(negedge clk);
    #2;
    reset = 1'b1;
    hold_lock = '0;
    #1;
    chk(bus.grant == '0 && !bus.write, "reset_midlock", {bus.grant, bus.write}, 64'd0);
    for (int i = 0; i < N; i++) pend[i].delete();
    exp_q.delete();
    wr_mode = 0;
    repeat (3) sample();
    @(negedge clk);
    reset = 1'b0;
    model_ptr = 0;
    repeat (2) sample();
    wr_mode = 1;
    for (int r = 0; r < N; r++) add_item(r, AW'(9'h030 + r), 32'hE000_0000 + r, 1'b0);
    run_phase("after_reset");
    gen_stim(2);
    run_phase("random_tail");

    chk(exp_q.size() == 0, "exp_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
